// File: rtl/contador_residuos_multicanal.sv
// N-channel debounced press counter with wrap/saturate count, per-channel clear and full flag.
// Optional aggregate press counter enabled by defining CONTADOR_TOTAL_EN.

module contador_residuos_canal #(
    parameter int LARGURA         = 3,
    parameter int LIMITE          = 7,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int MODO            = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               botao,
    input  logic               limpar,
    output logic [LARGURA-1:0] contagem,
    output logic               pulso
);
    localparam int SW = $clog2(DEBOUNCE_CICLOS);

    logic          sync1, sync2, db, db_d;
    logic [SW-1:0] estab;
    logic          press;

    // db_d delays the debounced level so the rising edge lands one cycle after db flips
    assign press = db & ~db_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db       <= 1'b0;
            db_d     <= 1'b0;
            estab    <= '0;
            pulso    <= 1'b0;
            contagem <= '0;
        end else begin
            sync1 <= botao;
            sync2 <= sync1;
            db_d  <= db;
            pulso <= press;
            if (sync2 == db) begin
                estab <= '0;
            end else if (estab == SW'(DEBOUNCE_CICLOS - 1)) begin
                db    <= ~db;
                estab <= '0;
            end else begin
                estab <= estab + 1'b1;
            end
            // clear has priority over a press on the same edge; pulso still fires
            if (limpar) begin
                contagem <= '0;
            end else if (press) begin
                if (contagem < LARGURA'(LIMITE))
                    contagem <= contagem + 1'b1;
                else if (MODO == 0)
                    contagem <= '0;
            end
        end
    end
endmodule

module contador_residuos_multicanal #(
    parameter int N_CANAIS        = 4,
    parameter int LARGURA         = 3,
    parameter int LIMITE          = 7,
    parameter int DEBOUNCE_CICLOS = 4,
`ifdef CONTADOR_TOTAL_EN
    parameter int LARGURA_TOTAL   = 8,
`endif
    parameter int MODO            = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_CANAIS-1:0]         botao,
    input  logic [N_CANAIS-1:0]         limpar,
`ifdef CONTADOR_TOTAL_EN
    input  logic                        limpar_total,
    output logic [LARGURA_TOTAL-1:0]    total,
`endif
    output logic [N_CANAIS*LARGURA-1:0] contagem,
    output logic [N_CANAIS-1:0]         cheio,
    output logic [N_CANAIS-1:0]         pulso
);
    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        contador_residuos_canal #(
            .LARGURA        (LARGURA),
            .LIMITE         (LIMITE),
            .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
            .MODO           (MODO)
        ) u_canal (
            .clk     (clk),
            .reset   (reset),
            .botao   (botao[i]),
            .limpar  (limpar[i]),
            .contagem(contagem[i*LARGURA +: LARGURA]),
            .pulso   (pulso[i])
        );
        assign cheio[i] = (contagem[i*LARGURA +: LARGURA] == LARGURA'(LIMITE));
    end

`ifdef CONTADOR_TOTAL_EN
    logic [LARGURA_TOTAL-1:0] soma;

    always_comb begin
        soma = '0;
        for (int i = 0; i < N_CANAIS; i++)
            soma = soma + LARGURA_TOTAL'(pulso[i]);
    end

    // accumulates the registered strobes, so it trails pulso by one edge; wraps naturally
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            total <= '0;
        else if (limpar_total)
            total <= '0;
        else
            total <= total + soma;
    end
`endif
endmodule

// File: tb/tb_contador_residuos_multicanal.sv
// Bench for contador_residuos_multicanal: wrap and saturate instances against a sample-window reference model.
module tb_contador_residuos_multicanal;
    localparam int N = 4, W = 3, LIM = 7, D = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] botao = '0, limpar = '0;
    logic limpar_total = 1'b0;
    logic [N*W-1:0] cont0, cont1;
    logic [N-1:0] cheio0, cheio1, pul0, pul1;
`ifdef CONTADOR_TOTAL_EN
    logic [7:0] tot0, tot1;
`endif

    always #5 clk = ~clk;

    contador_residuos_multicanal #(.N_CANAIS(N), .LARGURA(W), .LIMITE(LIM), .DEBOUNCE_CICLOS(D),
`ifdef CONTADOR_TOTAL_EN
        .LARGURA_TOTAL(8),
`endif
        .MODO(0)) u0 (
        .clk(clk), .reset(rst_n), .botao(botao), .limpar(limpar),
`ifdef CONTADOR_TOTAL_EN
        .limpar_total(limpar_total), .total(tot0),
`endif
        .contagem(cont0), .cheio(cheio0), .pulso(pul0));

    contador_residuos_multicanal #(.N_CANAIS(N), .LARGURA(W), .LIMITE(LIM), .DEBOUNCE_CICLOS(D),
`ifdef CONTADOR_TOTAL_EN
        .LARGURA_TOTAL(8),
`endif
        .MODO(1)) u1 (
        .clk(clk), .reset(rst_n), .botao(botao), .limpar(limpar),
`ifdef CONTADOR_TOTAL_EN
        .limpar_total(limpar_total), .total(tot1),
`endif
        .contagem(cont1), .cheio(cheio1), .pulso(pul1));

    int checks = 0, errors = 0;

    // Reference: synced sample = botao from two edges ago; db flips when the last D synced
    // samples all disagree with it; a rise strobes pulso one edge later.
    logic [D+1:0] hist [N];
    bit db_m [N], rose_m [N], pul_m [N];
    int cnt_m [2][N];
    int total_m;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            hist[c] = '0; db_m[c] = 0; rose_m[c] = 0; pul_m[c] = 0;
            cnt_m[0][c] = 0; cnt_m[1][c] = 0;
        end
        total_m = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] b, input logic [N-1:0] l, input logic lt);
        int pc = 0;
        for (int c = 0; c < N; c++) pc += int'(pul_m[c]);
        total_m = lt ? 0 : (total_m + pc) % 256;
        for (int c = 0; c < N; c++) begin
            pul_m[c] = rose_m[c];
            hist[c] = {hist[c][D:0], b[c]};
            rose_m[c] = 0;
            if (db_m[c] ? (hist[c][D+1:2] == '0) : (&hist[c][D+1:2])) begin
                db_m[c] = !db_m[c];
                rose_m[c] = db_m[c];
            end
            for (int m = 0; m < 2; m++) begin
                if (l[c]) cnt_m[m][c] = 0;
                else if (pul_m[c]) cnt_m[m][c] = (cnt_m[m][c] < LIM) ? cnt_m[m][c] + 1 : (m == 0 ? 0 : LIM);
            end
        end
    endtask

    task automatic compare_all();
        logic [N*W-1:0] e0, e1;
        logic [N-1:0] h0, h1, p;
        for (int c = 0; c < N; c++) begin
            e0[c*W +: W] = W'(cnt_m[0][c]);
            e1[c*W +: W] = W'(cnt_m[1][c]);
            h0[c] = (cnt_m[0][c] == LIM);
            h1[c] = (cnt_m[1][c] == LIM);
            p[c]  = pul_m[c];
        end
        check("model_contagem_wrap", 32'(cont0), 32'(e0));
        check("model_contagem_sat", 32'(cont1), 32'(e1));
        check("model_cheio_wrap", 32'(cheio0), 32'(h0));
        check("model_cheio_sat", 32'(cheio1), 32'(h1));
        check("model_pulso", 32'({pul1, pul0}), 32'({p, p}));
`ifdef CONTADOR_TOTAL_EN
        check("model_total", 32'({tot1, tot0}), 32'({8'(total_m), 8'(total_m)}));
`endif
    endtask

    task automatic step(input logic [N-1:0] b, input logic [N-1:0] l, input logic lt);
        botao = b; limpar = l; limpar_total = lt;
        @(posedge clk);
        model_edge(b, l, lt);
        #1 compare_all();
    endtask

    // hold mask for long enough to debounce, optionally clear at the pulso edge, then release
    task automatic press(input logic [N-1:0] mask, input logic [N-1:0] clr, input logic lt);
        for (int k = 0; k < D + 8; k++) begin
            step(mask, (k == D + 2) ? clr : '0, (k == D + 3) ? lt : 1'b0);
            if (k == D + 2) check("press_pulso", 32'(pul0), 32'(mask));
        end
        for (int k = 0; k < D + 6; k++) step('0, '0, 1'b0);
    endtask

    function automatic logic [N*W-1:0] pk(input int c3, input int c2, input int c1, input int c0);
        return {W'(c3), W'(c2), W'(c1), W'(c0)};
    endfunction

    typedef struct {
        logic [N-1:0]   mask;
        logic [N-1:0]   clr;
        logic [N*W-1:0] e0;
        logic [N*W-1:0] e1;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] m, input logic [N-1:0] c,
                                input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        vec_t v;
        v.mask = m; v.clr = c; v.e0 = a; v.e1 = b;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        logic [N-1:0] b;
        for (int i = 0; i < 9; i++)
            tbl[i] = mk(4'b0100, 4'b0000, pk(0, (i < 7) ? i + 1 : i - 7, 1, 1), pk(0, (i < 7) ? i + 1 : 7, 1, 1));
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(4'b1000, 4'b0000, pk(i - 8, 1, 1, 1), pk(i - 8, 7, 1, 1));
        tbl[14] = mk(4'b1000, 4'b1000, pk(0, 1, 1, 1), pk(0, 7, 1, 1));
        tbl[15] = mk(4'b1111, 4'b0000, pk(1, 2, 2, 2), pk(1, 7, 2, 2));

        model_reset();
        #12;
        check("reset_contagem", 32'({cont1, cont0}), 32'd0);
        check("reset_pulso_cheio", 32'({pul1, pul0, cheio1, cheio0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single held press: exactly one strobe, six edges after the first sampling edge
        for (int k = 0; k < 20; k++) begin
            step(4'b0001, '0, 1'b0);
            check("t1_pulso_timing", 32'(pul0[0]), 32'(k == 6));
        end
        for (int k = 0; k < 12; k++) step('0, '0, 1'b0);
        check("t1_contagem", 32'(cont0), 32'(pk(0, 0, 0, 1)));

        // short glitches never count, the clean hold does
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 3; k++) step(4'b0010, '0, 1'b0);
            for (int k = 0; k < 3; k++) step('0, '0, 1'b0);
        end
        check("t2_glitch_nocount", 32'(cont0), 32'(pk(0, 0, 0, 1)));
        press(4'b0010, '0, 1'b0);
        check("t2_contagem", 32'(cont0), 32'(pk(0, 0, 1, 1)));

        for (int i = 0; i < 16; i++) begin
            press(tbl[i].mask, tbl[i].clr, 1'b0);
            check($sformatf("tbl%0d_wrap", i), 32'(cont0), 32'(tbl[i].e0));
            check($sformatf("tbl%0d_sat", i), 32'(cont1), 32'(tbl[i].e1));
            check($sformatf("tbl%0d_cheio", i), 32'(cheio0[2]), 32'(tbl[i].e0[8:6] == 3'd7));
        end

        // async reset mid-debounce with ch0 at 3
        press(4'b0001, '0, 1'b0);
        check("t5_pre", 32'(cont0[2:0]), 32'd3);
        for (int k = 0; k < 3; k++) step(4'b0001, '0, 1'b0);
        #2 rst_n = 1'b0; botao = '0;
        #1;
        check("t5_rst_contagem", 32'({cont1, cont0}), 32'd0);
        check("t5_rst_pulso_cheio", 32'({pul1, pul0, cheio1, cheio0}), 32'd0);
        model_reset();
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) step('0, '0, 1'b0);

`ifdef CONTADOR_TOTAL_EN
        step('0, '0, 1'b1);
        for (int i = 0; i < 64; i++) press(4'b1111, '0, 1'b0);
        check("t6_total_wrap", 32'(tot0), 32'd0);
        press(4'b0001, '0, 1'b0);
        check("t6_total_one", 32'(tot0), 32'd1);
        press(4'b0011, '0, 1'b1);
        check("t6_total_clear", 32'(tot0), 32'd0);
`endif

        // randomized run against the model
        b = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(5) == 0) b[c] = ~b[c];
            step(b, ($urandom_range(15) == 0) ? 4'($urandom) : '0, $urandom_range(31) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
